// File: rtl/vectadd_from_hw_sig_pkg.sv
// Shared definitions for the vector-adder PIO ports: register word addresses,
// edge-type encodings and the synchroniser priming length.
package vectadd_from_hw_sig_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Edge detection stays disarmed until the reset zeros have left the
  // synchroniser and prev, so a line already high at reset is not an edge.
  function automatic int prime_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/vectadd_sync_edge.sv
// Input synchroniser plus edge detector for the hardware status lines.
// Emits the synchronised level and a one-cycle edge pulse per bit.
module vectadd_sync_edge
  import vectadd_from_hw_sig_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_in_port,
  output logic [WIDTH-1:0] o_sync_q,
  output logic [WIDTH-1:0] o_edge
);

  localparam int               PRIME_CYC = prime_cycles(SYNC_STAGES);
  localparam int               CNT_W     = $clog2(PRIME_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(PRIME_CYC);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [CNT_W-1:0]                  r_prime_cnt;
  logic                              w_primed;
  logic [WIDTH-1:0]                  w_edge_raw;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign o_sync_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev      <= '0;
      r_prime_cnt <= '0;
    end else begin
      r_prev <= o_sync_q;
      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + CNT_W'(1);
      end
    end
  end

  assign w_primed = (r_prime_cnt == CNT_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign w_edge_raw[gi] = ~o_sync_q[gi] & r_prev[gi];
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign w_edge_raw[gi] = o_sync_q[gi] ^ r_prev[gi];
      end else begin : g_rise
        assign w_edge_raw[gi] = o_sync_q[gi] & ~r_prev[gi];
      end
    end
  endgenerate

  assign o_edge = w_primed ? w_edge_raw : '0;

endmodule

// File: rtl/vectadd_from_hw_sig.sv
// Avalon-MM status input port: synchronised level, sticky edge capture with
// write-1-to-clear, interrupt mask and a flop-driven level interrupt.
module vectadd_from_hw_sig
  import vectadd_from_hw_sig_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_edge;
  logic             w_wr;
  logic [WIDTH-1:0] w_mask_next;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_cap_next;
  logic [31:0]      w_rdata;

  vectadd_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_in_port(in_port),
    .o_sync_q (w_sync_q),
    .o_edge   (w_edge)
  );

  assign w_wr        = chipselect & ~write_n;
  assign w_mask_next = (w_wr && reg_addr_e'(address) == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : r_irq_mask;
  assign w_clr       = (w_wr && reg_addr_e'(address) == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // A new edge overrides a same-cycle clear so no event is ever dropped.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cap
      assign w_cap_next[gi] = w_edge[gi] | (r_edge_cap[gi] & ~w_clr[gi]);
    end
    if (WIDTH < 32) begin : g_wdata_hi
      logic w_unused_wdata;
      assign w_unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:    w_rdata[WIDTH-1:0] = w_sync_q;
      ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edge_cap;
      default:      w_rdata = '0;
    endcase
  end

  // irq is registered from next-state values: clean, and it tracks a mask
  // write or clear in the same clock that updates the registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_mask <= w_mask_next;
      r_edge_cap <= w_cap_next;
      r_readdata <= w_rdata;
      r_irq      <= |(w_cap_next & w_mask_next);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
